// File: rtl/avalon_rl_sink.sv
// Avalon-ST sink for a READY_LATENCY source: credit-tracked skid buffer that
// re-presents the stream as a zero-latency valid/ready port and flags upstream protocol errors.
module avalon_rl_sink #(
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int READY_LATENCY       = 3,
    parameter int DEPTH               = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] snk_data,
    input  logic                                            snk_valid,
    output logic                                            snk_ready,
    output logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] src_data,
    output logic                                            src_valid,
    input  logic                                            src_ready,
    output logic [DEPTH:0]                                  level,
    output logic                                            proto_err
);

    localparam int WIDTH   = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int ENTRIES = 1 << DEPTH;
    localparam int RL      = READY_LATENCY;
    localparam int CW      = $clog2(RL + 1);
    localparam int SW      = DEPTH + 2;

    logic [DEPTH:0]     count_q, count_d;
    logic [DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [RL-1:0]      hist_q, hist_d;
    logic               err_q, err_d;
    logic               rdy_en_q;
    logic [WIDTH-1:0]   mem_q [ENTRIES];

    logic [CW-1:0]      credits;
    logic [SW-1:0]      occ;
    logic               push, pop, space, legal;

    // Outstanding credits: every ready asserted within the last RL cycles may still deliver a beat.
    always_comb begin
        credits = '0;
        for (int i = 0; i < RL; i++) begin
            credits = credits + CW'(hist_q[i]);
        end
    end

    assign occ       = SW'(count_q) + SW'(credits);
    assign snk_ready = rdy_en_q & (occ < SW'(ENTRIES));

    assign src_valid = (count_q != '0);
    assign src_data  = src_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = count_q;
    assign proto_err = err_q;

    assign pop   = src_valid & src_ready;
    assign legal = hist_q[RL-1];
    // A full buffer can still take a beat when the same cycle frees the head slot.
    assign space = (count_q != (DEPTH+1)'(ENTRIES)) | pop;
    assign push  = snk_valid & space;

    always_comb begin
        hist_d    = '0;
        hist_d[0] = snk_ready;
        for (int i = 1; i < RL; i++) begin
            hist_d[i] = hist_q[i-1];
        end
        count_d  = count_q + (DEPTH+1)'(push) - (DEPTH+1)'(pop);
        wr_ptr_d = wr_ptr_q + DEPTH'(push);
        rd_ptr_d = rd_ptr_q + DEPTH'(pop);
        err_d    = err_q | (snk_valid & (~legal | ~space));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            hist_q   <= '0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            hist_q   <= hist_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= snk_data;
        end
    end

endmodule

// File: tb/tb_avalon_rl_sink.sv
// Self-checking bench for avalon_rl_sink: hand-derived vector table, directed
// multi-cycle sequences and random traffic against a queue-based reference.
module tb_avalon_rl_sink;

    localparam int W  = 32;
    localparam int RL = 3;
    localparam int D  = 4;
    localparam int N  = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] snk_data;
    logic         snk_valid;
    logic         snk_ready;
    logic [W-1:0] src_data;
    logic         src_valid;
    logic         src_ready;
    logic [D:0]   level;
    logic         proto_err;

    always #5 clk = ~clk;

    avalon_rl_sink #(
        .DATABITS_PER_SYMBOL(8),
        .SYMBOLS_PER_BEAT   (4),
        .READY_LATENCY      (RL),
        .DEPTH              (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .snk_data (snk_data),
        .snk_valid(snk_valid),
        .snk_ready(snk_ready),
        .src_data (src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .level    (level),
        .proto_err(proto_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference: buffer contents as a queue, expected ready history, sticky error.
    logic [W-1:0]  mq[$];
    logic [RL-1:0] mhist = '0;
    bit            men   = 1'b0;
    bit            merr  = 1'b0;
    logic [W-1:0]  got[$];

    typedef struct {
        bit           r;
        bit           v;
        logic [W-1:0] d;
        bit           sr;
        logic [D:0]   lvl;
        bit           sv;
        bit           rdy;
        bit           err;
        logic [W-1:0] data;
    } vec_t;

    vec_t vecs[14];

    function automatic bit m_ready();
        int c = 0;
        for (int i = 0; i < RL; i++) c += int'(mhist[i]);
        return men && ((mq.size() + c) < N);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [W-1:0] d, input bit sr);
        bit rdy;
        bit legal;
        logic [63:0] exp;
        rst = r; snk_valid = v; snk_data = d; src_ready = sr;
        rdy   = m_ready();
        legal = mhist[RL-1];
        if (r && src_valid && sr) got.push_back(src_data);
        @(posedge clk);
        if (!r) begin
            mq.delete();
            mhist = '0;
            men   = 1'b0;
            merr  = 1'b0;
        end else begin
            if (v && !legal) merr = 1'b1;
            if (mq.size() != 0 && sr) void'(mq.pop_front());
            if (v) begin
                if (mq.size() < N) mq.push_back(d);
                else merr = 1'b1;
            end
            mhist = {mhist[RL-2:0], rdy};
            men   = 1'b1;
        end
        @(negedge clk);
        exp = {24'd0, 5'(mq.size()), mq.size() != 0, m_ready(), merr,
               (mq.size() != 0) ? mq[0] : 32'd0};
        check("model", {24'd0, level, src_valid, snk_ready, proto_err, src_data}, exp);
    endtask

    // Send n beats base+1..base+n whenever legal with src_ready high; collect output.
    task automatic stream(input int n, input logic [W-1:0] base);
        int sent = 0;
        bit v;
        got.delete();
        for (int c = 0; c < 50 && got.size() < n; c++) begin
            v = (sent < n) && mhist[RL-1];
            cycle(1'b1, v, v ? base + W'(sent + 1) : '0, 1'b1);
            if (v && sent == 0) check("stream_latency", 64'(src_valid), 64'd1);
            if (v) sent++;
        end
        check("stream_count", 64'(got.size()), 64'(n));
        for (int i = 0; i < got.size(); i++)
            check("stream_order", 64'(got[i]), 64'(base + W'(i + 1)));
        check("stream_err", 64'(proto_err), 64'd0);
    endtask

    // Fill with src_ready low, sending whenever allowed; returns number sent.
    task automatic fill(input logic [W-1:0] base, output int sent);
        bit v;
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            v = mhist[RL-1];
            cycle(1'b1, v, v ? base + W'(sent + 1) : '0, 1'b0);
            if (v) sent++;
        end
    endtask

    task automatic drain(input int cycles);
        got.delete();
        for (int c = 0; c < cycles; c++) cycle(1'b1, 1'b0, '0, 1'b1);
    endtask

    initial begin
        int sent;
        rst = 1'b0; snk_valid = 1'b0; snk_data = '0; src_ready = 1'b0;

        //          r  v  d             sr  lvl sv rdy err data
        vecs[0]  = '{0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0};
        vecs[1]  = '{1, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0};
        vecs[2]  = '{1, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0};
        vecs[3]  = '{1, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0};
        vecs[4]  = '{1, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0};
        vecs[5]  = '{1, 1, 32'h11111111, 0, 1, 1, 1, 0, 32'h11111111};
        vecs[6]  = '{1, 1, 32'h22222222, 0, 2, 1, 1, 0, 32'h11111111};
        vecs[7]  = '{1, 0, 32'h0,        1, 1, 1, 1, 0, 32'h22222222};
        vecs[8]  = '{1, 0, 32'h0,        1, 0, 0, 1, 0, 32'h0};
        vecs[9]  = '{1, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0};
        vecs[10] = '{0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0};
        vecs[11] = '{1, 1, 32'hDEADBEEF, 0, 1, 1, 1, 1, 32'hDEADBEEF};
        vecs[12] = '{1, 0, 32'h0,        0, 1, 1, 1, 1, 32'hDEADBEEF};
        vecs[13] = '{1, 0, 32'h0,        1, 0, 0, 1, 1, 32'h0};

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].sr);
            check($sformatf("vec%0d", i),
                  {24'd0, level, src_valid, snk_ready, proto_err, src_data},
                  {24'd0, vecs[i].lvl, vecs[i].sv, vecs[i].rdy, vecs[i].err, vecs[i].data});
        end

        cycle(1'b0, 1'b0, '0, 1'b0);
        stream(20, 32'h0);

        fill(32'h100, sent);
        check("fill_sent", 64'(sent), 64'd16);
        check("fill_level", 64'(level), 64'd16);
        check("fill_ready", 64'(snk_ready), 64'd0);
        check("fill_err", 64'(proto_err), 64'd0);
        drain(20);
        check("drain_count", 64'(got.size()), 64'd16);
        for (int i = 0; i < got.size(); i++)
            check("drain_order", 64'(got[i]), 64'(32'h100 + i + 1));
        check("drain_ready", 64'(snk_ready), 64'd1);

        fill(32'h200, sent);
        check("fill2_level", 64'(level), 64'd16);
        cycle(1'b1, 1'b1, 32'hBADBAD00, 1'b0);
        check("ovf_level", 64'(level), 64'd16);
        check("ovf_err", 64'(proto_err), 64'd1);
        got.delete();
        cycle(1'b1, 1'b1, 32'hCAFE0001, 1'b1);
        check("fullpp_level", 64'(level), 64'd16);
        check("fullpp_pop", 64'(got.size() == 1 ? got[0] : 32'hFFFFFFFF), 64'h201);
        check("fullpp_head", 64'(src_data), 64'h202);
        drain(20);
        check("fullpp_drain_cnt", 64'(got.size()), 64'd16);
        check("fullpp_tail", 64'(got.size() == 16 ? got[15] : 32'hFFFFFFFF), 64'hCAFE0001);
        check("err_sticky", 64'(proto_err), 64'd1);

        sent = 0;
        for (int c = 0; c < 30 && sent < 7; c++) begin
            if (mhist[RL-1]) begin
                cycle(1'b1, 1'b1, 32'h400 + W'(sent), 1'b0);
                sent++;
            end else begin
                cycle(1'b1, 1'b0, '0, 1'b0);
            end
        end
        check("mid_level", 64'(level), 64'd7);
        cycle(1'b0, 1'b0, '0, 1'b0);
        check("rst_state", {60'd0, level == 0, src_valid, snk_ready, proto_err}, 64'h8);
        stream(20, 32'h300);

        cycle(1'b0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            bit v;
            v = mhist[RL-1] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
            cycle($urandom_range(0, 199) != 0, v, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
